if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and fetch-address sequencing, and runs a request/ready handshake with instruction memory. Absorbs memory wait states, hazard stalls and taken-branch redirects. Drives the instruction word, PC+4 and a flush request into IF/ID.

Parameters:
RESET_PC, 32'h00000000, fetch address loaded on reset
TIMEOUT, 16, wait-cycle limit for the optional watchdog (valid range 2..255)

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  synchronous reset, active-low (0 = reset)
PC_LE  input  1  hazard-unit load enable; 0 = stall fetch
BR_TAKEN  input  1  taken branch resolved in ID
BR_TARGET  input  32  branch target; bits [1:0] are forced to 00 internally
IMEM_REQ  output  1  instruction memory request
IMEM_ADDR  output  32  word-aligned fetch address
IMEM_RDATA  input  32  instruction word; valid when IMEM_READY=1
IMEM_READY  input  1  memory data valid this cycle
Instr_Out  output  32  instruction word to the IF/ID input
PC4_Out  output  32  fetch address + 4, to IF/ID PC4 input
Valid_Out  output  1  Instr_Out holds a real instruction
IFID_CLR  output  1  flush request to IF/ID (active-high, combinational = BR_TAKEN)
FETCH_ERR  output  1  sticky watchdog error (see Optional Feature)

Behaviour:
- Registers: FA (fetch address / PC), TGT (pending redirect target), HBUF (held instruction), 2-bit state.
- Reset (CLR=0 at edge):
  - FA=RESET_PC; state=IDLE.
  - Instr_Out=0, PC4_Out=0, Valid_Out=0, IMEM_REQ=0, FETCH_ERR=0, HBUF=0, TGT=0.
  - Reset overrides all other inputs, including mid-handshake; an in-flight response is ignored.
- IMEM_REQ=1 only in FETCH and DRAIN. IMEM_ADDR=FA in all states. Address and request stay stable until READY is seen.
- Priority in every state: reset > BR_TAKEN > PC_LE.
- State IDLE: REQ=0; always transitions to FETCH on the next edge. First request appears one cycle after reset is released.
- State FETCH:
  - BR_TAKEN & READY: discard RDATA; FA<=BR_TARGET; Instr_Out<=0; Valid_Out<=0; stay FETCH.
  - BR_TAKEN & !READY: TGT<=BR_TARGET; Instr_Out<=0; Valid_Out<=0; go DRAIN.
  - READY & PC_LE: Instr_Out<=RDATA; PC4_Out<=FA+4; Valid_Out<=1; FA<=FA+4; stay FETCH. This gives back-to-back fetches, one instruction per cycle.
  - READY & !PC_LE: HBUF<=RDATA; outputs hold; go HOLD.
  - !READY & PC_LE: Valid_Out<=0 (bubble); Instr_Out<=0.
  - !READY & !PC_LE: all outputs hold.
- State HOLD: REQ=0.
  - BR_TAKEN: FA<=BR_TARGET; drop HBUF; Valid_Out<=0; go FETCH.
  - PC_LE: Instr_Out<=HBUF; PC4_Out<=FA+4; Valid_Out<=1; FA<=FA+4; go FETCH.
  - Otherwise: hold.
- State DRAIN: REQ=1, ADDR=old FA; Valid_Out=0.
  - BR_TAKEN again: TGT<=new BR_TARGET (latest wins).
  - READY: discard RDATA; FA<=TGT (or the same-cycle BR_TARGET if BR_TAKEN); go FETCH.
- Latency: IMEM_READY to Valid_Out is 1 cycle.
- Arithmetic: FA+4 is modulo 2^32; 0xFFFFFFFC+4 = 0x00000000, no flag.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each cycle in FETCH/DRAIN with READY=0, and clears on READY, on leaving those states, or on reset.
  - When the counter reaches TIMEOUT, FETCH_ERR<=1 (sticky until reset); fetch itself continues to wait.
- Undefined: no counter logic; FETCH_ERR is tied 0.

Test Plan:
1. RESET_PC=0, READY=1 constantly, PC_LE=1 -> IMEM_ADDR 0,4,8,12 on successive cycles from cycle 1 after reset; Valid_Out=1 from cycle 2; PC4_Out 4,8,12.
2. READY=0 for 3 cycles at ADDR 0x8 -> REQ=1 and ADDR=0x8 held; Valid_Out=0 and Instr_Out=0 for 3 cycles; resumes with PC4_Out=0xC.
3. READY=1 with RDATA=0xE0810002 at ADDR 0x10 while PC_LE=0 -> HOLD entered, REQ=0; PC_LE=1 two cycles later -> Instr_Out=0xE0810002, PC4_Out=0x14, next IMEM_ADDR=0x14.
4. BR_TAKEN=1, BR_TARGET=0x103 at ADDR 0x20 with READY=0 -> IFID_CLR=1 that cycle; DRAIN keeps ADDR 0x20 until READY (data discarded, Valid_Out=0); then IMEM_ADDR=0x100.
5. RESET_PC=0xFFFFFFFC, READY=1 -> PC4_Out=0x00000000, next IMEM_ADDR=0x0; CLR=0 asserted mid-wait -> all outputs zero, ADDR=RESET_PC next edge.
6. FETCH_TIMEOUT_EN defined, TIMEOUT=8, READY held 0 -> FETCH_ERR=1 after the 8th wait cycle, stays 1 after READY returns; undefined build -> FETCH_ERR=0 throughout.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
//   IMEM_REQ    fetch -> imem : request valid
//   IMEM_ADDR   fetch -> imem : word-aligned fetch address
//   IMEM_RDATA  imem -> fetch : instruction word, valid with IMEM_READY
//   IMEM_READY  imem -> fetch : response valid this cycle
interface if_fetch_stage_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_READY;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_RDATA,
        input  IMEM_READY
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_RDATA,
        output IMEM_READY
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage feeding the IF/ID pipeline register.
// Owns the fetch address (PC), handshakes with instruction memory, absorbs
// memory wait states, hazard stalls and taken-branch redirects.
//
// Ports:
//   CLK        clock, rising edge
//   CLR        synchronous reset, active-low
//   PC_LE      hazard-unit load enable (0 = stall)
//   BR_TAKEN   taken branch resolved in ID
//   BR_TARGET  branch target (low two bits ignored)
//   imem       instruction-memory bus (master side)
//   Instr_Out  instruction word to IF/ID
//   PC4_Out    fetch address + 4 to IF/ID
//   Valid_Out  Instr_Out holds a real instruction
//   IFID_CLR   IF/ID flush request (combinational copy of BR_TAKEN)
//   FETCH_ERR  sticky memory-wait watchdog error
//
// Build option: define FETCH_TIMEOUT_EN to enable the wait-cycle watchdog;
// otherwise FETCH_ERR is tied low.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic               PC_LE,
    input  logic               BR_TAKEN,
    input  logic [31:0]        BR_TARGET,
    if_fetch_stage_if.master   imem,
    output logic [31:0]        Instr_Out,
    output logic [31:0]        PC4_Out,
    output logic               Valid_Out,
    output logic               IFID_CLR,
    output logic               FETCH_ERR
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   fa_q;
    logic [XLEN-1:0]   tgt_q;
    logic [XLEN-1:0]   hbuf_q;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   pc4_q;
    logic              valid_q;
    logic              req_q;

    logic [XLEN-1:0]   br_tgt;
    logic [XLEN-1:0]   fa_inc;
    logic              ready;
    logic              unused_bits;

    assign br_tgt = {BR_TARGET[XLEN-1:2], 2'b00};
    assign fa_inc = fa_q + XLEN'(4);
    assign ready  = imem.IMEM_READY;

    assign imem.IMEM_REQ  = req_q;
    assign imem.IMEM_ADDR = fa_q;
    assign Instr_Out      = instr_q;
    assign PC4_Out        = pc4_q;
    assign Valid_Out      = valid_q;
    assign IFID_CLR       = BR_TAKEN;

    assign unused_bits = ^{BR_TARGET[1:0], CNT_W'(TIMEOUT)};

    // Fetch sequencer; priority is reset > branch redirect > load enable.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            fa_q    <= RESET_PC;
            tgt_q   <= '0;
            hbuf_q  <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // No request is outstanding, so a redirect just reloads FA.
                    if (BR_TAKEN) begin
                        fa_q <= br_tgt;
                    end
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end

                S_FETCH: begin
                    if (BR_TAKEN) begin
                        instr_q <= '0;
                        valid_q <= 1'b0;
                        if (ready) begin
                            fa_q <= br_tgt;
                        end else begin
                            // Request must stay stable until answered; park the target.
                            tgt_q   <= br_tgt;
                            state_q <= S_DRAIN;
                        end
                    end else if (ready) begin
                        if (PC_LE) begin
                            instr_q <= imem.IMEM_RDATA;
                            pc4_q   <= fa_inc;
                            valid_q <= 1'b1;
                            fa_q    <= fa_inc;
                        end else begin
                            hbuf_q  <= imem.IMEM_RDATA;
                            state_q <= S_HOLD;
                            req_q   <= 1'b0;
                        end
                    end else if (PC_LE) begin
                        instr_q <= '0;
                        valid_q <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (BR_TAKEN) begin
                        fa_q    <= br_tgt;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end else if (PC_LE) begin
                        instr_q <= hbuf_q;
                        pc4_q   <= fa_inc;
                        valid_q <= 1'b1;
                        fa_q    <= fa_inc;
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    // Wrong-path response is discarded; newest target wins.
                    if (ready) begin
                        fa_q    <= BR_TAKEN ? br_tgt : tgt_q;
                        state_q <= S_FETCH;
                    end else if (BR_TAKEN) begin
                        tgt_q <= br_tgt;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q;
    logic             waiting;

    // req_q is high exactly in FETCH and DRAIN.
    assign waiting = req_q && !ready;
    assign cnt_inc = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

    // Watchdog: error flags on the edge that completes the TIMEOUT-th wait cycle.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (waiting) begin
            wait_cnt_q <= cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
                err_q <= 1'b1;
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign FETCH_ERR = err_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

endmodule
